sdram_dq_sched: RTL
===================

Name: sdram_dq_sched

Overview:
- Data-phase scheduler for the SDRAM DQ bus. Sits between the SDRAM command sequencer and the bank of per-bit registered DQ pad buffers.
- For each READ/WRITE the sequencer issues, it drives write data and output enable at the correct cycles and flags returning read beats.
- Enforces bus-turnaround and burst spacing by gating command acceptance.

Parameters:
- W, 16, DQ width in bits.
- BURST_LEN, 4, beats per burst; legal values 1, 2, 4, 8.
- CAS_LATENCY, 2, SDRAM CL; legal values 2, 3.

Ports:
- clk  in  1  system clock; also clocks the DQ pad buffers and command pads.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  sequencer wants to issue READ/WRITE this cycle.
- cmd_write  in  1  1 = WRITE, 0 = READ; qualified by cmd_valid.
- cmd_ready  out  1  command of type cmd_write is legal this cycle.
- wdata  in  W  write beat from upstream.
- wdata_ready  out  1  wdata consumed this cycle.
- rdata  out  W  read beat to upstream.
- rdata_valid  out  1  rdata holds a valid beat this cycle.
- dq_o  out  W  to pad buffer o inputs.
- dq_oe  out  1  to all pad buffer oe inputs.
- dq_i  in  W  from pad buffer i outputs.
- busy  out  1  any burst in flight, or turnaround pending.

Behaviour:
- Pad timing, fixed:
  - Command pads and DQ o/oe are registered by 1 cycle.
  - DQ input is registered by 1 cycle.
  - A command accepted in core cycle T reaches the pins at T+1.
- Accept = cmd_valid & cmd_ready.
  - cmd_ready is combinational from internal counters and cmd_write.
  - cmd_valid with cmd_ready=0 is ignored; the sequencer must hold and not drive pins.
- WRITE accepted at T:
  - wdata_ready=1 and dq_oe=1 in cycles T..T+BURST_LEN-1; asserted combinationally in cycle T.
  - dq_o=wdata in those cycles; otherwise dq_o=0, dq_oe=0.
  - No stall: upstream must present valid wdata whenever wdata_ready=1.
- READ accepted at T:
  - rdata_valid=1 in cycles T+CAS_LATENCY+2+k, k=0..BURST_LEN-1.
  - rdata=dq_i combinationally when valid; otherwise rdata=0.
  - Multiple reads overlap in the pipeline; read tracking must support one accept every BURST_LEN cycles without dropping beats.
- Spacing rules (no burst interruption):
  - Any command after any command at T: earliest accept T+BURST_LEN.
  - WRITE after READ at T: earliest accept T+CAS_LATENCY+BURST_LEN+1. This leaves one pad-cycle turnaround between the last read beat on the pins (T+CAS_LATENCY+BURST_LEN) and the first driven write beat.
  - READ after WRITE: T+BURST_LEN is sufficient.
  - Implementation: two down-counters, rd_block and wr_block. cmd_ready = cmd_write ? (wr_block==0) : (rd_block==0).
  - Counters load on accept and saturate at 0.
- busy = any block counter nonzero | write beats remaining | read beats pending.
- Reset values (asynchronous, immediate):
  - All counters and read pipeline cleared.
  - dq_oe=0, dq_o=0, wdata_ready=0, rdata_valid=0, rdata=0, busy=0, cmd_ready=1.
- Reset mid-operation:
  - In-flight bursts are discarded.
  - No rdata_valid or dq_oe after release until a new command is accepted.
  - cmd_valid during reset is ignored.

Test Plan:
All scenarios use W=16, BURST_LEN=4, CAS_LATENCY=2.
1. Reset with cmd_valid=1 -> all outputs at reset values, cmd_ready=1; first cycle after release accepts.
2. WRITE at cycle 10, wdata 0x1111, 0x2222, 0x3333, 0x4444 -> wdata_ready=dq_oe=1 cycles 10–13, dq_o matches per cycle, cmd_ready=0 cycles 11–13, cmd_ready=1 at 14, dq_oe=0 at 14.
3. READ at 20, dq_i=0xA0..0xA3 in cycles 24–27 -> rdata_valid=1 exactly 24–27 with those values, busy=0 at 28.
4. READs at 20 and 24 -> rdata_valid continuously 24–31, 8 beats in order; a READ attempted at 22 is refused (cmd_ready=0).
5. READ at 20, WRITE held from 21 -> cmd_ready=0 for the write in 21–26; accepted at 27; dq_oe first high at 27; READ requests would be ready at 24.
6. READ at 20, rst_n low at 25 for 2 cycles -> rdata_valid drops to 0 at 25 asynchronously, stays 0 through 31; busy=0; cmd_ready=1 after release.

Source files
------------

// File: rtl/sdram_dq_sched.sv
// sdram_dq_sched: DQ data-phase scheduler between the SDRAM command sequencer
// and the registered DQ pad buffers. It drives write beats and output enable,
// flags returning read beats, and gates command acceptance for burst spacing
// and read-to-write bus turnaround.
module sdram_dq_sched #(
   parameter int unsigned W           = 16,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned CAS_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   input  logic         cmd_write,
   output logic         cmd_ready,
   input  logic [W-1:0] wdata,
   output logic         wdata_ready,
   output logic [W-1:0] rdata,
   output logic         rdata_valid,
   output logic [W-1:0] dq_o,
   output logic         dq_oe,
   input  logic [W-1:0] dq_i,
   output logic         busy
);

   // Longest blocking interval: a write following a read.
   localparam int unsigned BLK_MAX = CAS_LATENCY + BURST_LEN;
   localparam int unsigned CNT_W   = $clog2(BLK_MAX + 1);
   // Read beat tracker: bit 0 marks a valid beat in the current cycle.
   localparam int unsigned PIPE_D  = CAS_LATENCY + 1 + BURST_LEN;

   // A read accepted at T sets bits CAS_LATENCY+1 .. PIPE_D-1, which shift down
   // to bit 0 in cycles T+CAS_LATENCY+2 .. T+CAS_LATENCY+BURST_LEN+1.
   localparam logic [PIPE_D-1:0] RD_MASK  = {{BURST_LEN{1'b1}}, {(CAS_LATENCY + 1){1'b0}}};
   // Counter load values: a counter loaded with N releases its command type N+1 cycles later.
   localparam logic [CNT_W-1:0]  SPACE_LD = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  TURN_LD  = CNT_W'(BLK_MAX);
   localparam logic [CNT_W-1:0]  BEATS_LD = CNT_W'(BURST_LEN - 1);

   logic [CNT_W-1:0]  r_rd_block;
   logic [CNT_W-1:0]  r_wr_block;
   logic [CNT_W-1:0]  r_wr_left;
   logic [PIPE_D-1:0] r_rd_pipe;

   logic w_accept;
   logic w_acc_wr;
   logic w_acc_rd;
   logic w_wr_active;

   // Acceptance: ready depends only on the blocking counter of the requested type.
   assign cmd_ready = cmd_write ? (r_wr_block == '0) : (r_rd_block == '0);
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_acc_wr  = w_accept & cmd_write;
   assign w_acc_rd  = w_accept & ~cmd_write;

   // Write beat window: the accept cycle itself plus the remaining beats.
   // rst_n masks the accept-cycle term so nothing is driven while in reset.
   assign w_wr_active = (w_acc_wr & rst_n) | (r_wr_left != '0);
   assign wdata_ready = w_wr_active;
   assign dq_oe       = w_wr_active;
   assign dq_o        = w_wr_active ? wdata : '0;

   // Read return: pass the pad input through only on tracked beats.
   assign rdata_valid = r_rd_pipe[0];
   assign rdata       = r_rd_pipe[0] ? dq_i : '0;

   assign busy = (r_rd_block != '0) | (r_wr_block != '0) | (r_wr_left != '0) | (|r_rd_pipe);

   // Blocking counters, write beat counter and read beat tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_block <= '0;
         r_wr_block <= '0;
         r_wr_left  <= '0;
         r_rd_pipe  <= '0;
      end else begin
         r_rd_pipe <= (r_rd_pipe >> 1) | (w_acc_rd ? RD_MASK : '0);

         if (w_accept) begin
            r_rd_block <= SPACE_LD;
            r_wr_block <= w_acc_rd ? TURN_LD : SPACE_LD;
         end else begin
            r_rd_block <= (r_rd_block != '0) ? r_rd_block - CNT_W'(1) : '0;
            r_wr_block <= (r_wr_block != '0) ? r_wr_block - CNT_W'(1) : '0;
         end

         if (w_acc_wr) begin
            r_wr_left <= BEATS_LD;
         end else begin
            r_wr_left <= (r_wr_left != '0) ? r_wr_left - CNT_W'(1) : '0;
         end
      end
   end

endmodule
